// File: rtl/i2s_tdm_clkws_gen_if.sv
// rtl/i2s_tdm_clkws_gen_if.sv - per-generator enable/config inputs and SCK/WS outputs
interface i2s_tdm_clkws_gen_if #(
  parameter int NUM_GEN = 2,
  parameter int DIV_W   = 16,
  parameter int SLOT_W  = 3
);
  logic [NUM_GEN-1:0]        en_i;
  logic [NUM_GEN*DIV_W-1:0]  cfg_div_i;
  logic [NUM_GEN*5-1:0]      cfg_word_size_i;
  logic [NUM_GEN*SLOT_W-1:0] cfg_slot_num_i;
  logic [NUM_GEN-1:0]        cfg_ws_mode_i;
  logic [NUM_GEN-1:0]        cfg_ws_delay_i;
  logic [NUM_GEN-1:0]        cfg_ws_pol_i;
  logic [NUM_GEN-1:0]        sck_o;
  logic [NUM_GEN-1:0]        ws_o;
  logic [NUM_GEN-1:0]        sck_rise_o;
  logic [NUM_GEN-1:0]        sck_fall_o;
  logic [NUM_GEN-1:0]        frame_start_o;
  logic [NUM_GEN*SLOT_W-1:0] slot_idx_o;
  logic [NUM_GEN-1:0]        busy_o;

  modport master (
    output en_i, cfg_div_i, cfg_word_size_i, cfg_slot_num_i,
           cfg_ws_mode_i, cfg_ws_delay_i, cfg_ws_pol_i,
    input  sck_o, ws_o, sck_rise_o, sck_fall_o, frame_start_o, slot_idx_o, busy_o
  );

  modport slave (
    input  en_i, cfg_div_i, cfg_word_size_i, cfg_slot_num_i,
           cfg_ws_mode_i, cfg_ws_delay_i, cfg_ws_pol_i,
    output sck_o, ws_o, sck_rise_o, sck_fall_o, frame_start_o, slot_idx_o, busy_o
  );
endinterface

// File: rtl/i2s_tdm_clkws_gen.sv
// rtl/i2s_tdm_clkws_gen.sv - NUM_GEN independent I2S/TDM SCK and WS generators
module i2s_tdm_clkws_gen #(
  parameter int NUM_GEN = 2,
  parameter int DIV_W   = 16,
  parameter int SLOT_W  = 3
) (
  input logic clk_i,
  input logic rst_i,
  i2s_tdm_clkws_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

  function automatic logic [4:0] next_bit(input logic [4:0] b, input logic [4:0] w);
    return (b == w) ? 5'd0 : b + 5'd1;
  endfunction

  function automatic logic [SLOT_W-1:0] next_slot(input logic [4:0] b, input logic [4:0] w,
                                                  input logic [SLOT_W-1:0] s,
                                                  input logic [SLOT_W-1:0] n);
    if (b != w) return s;
    return (s == n) ? {SLOT_W{1'b0}} : s + SLOT_W'(1);
  endfunction

  function automatic logic ws_raw(input logic mode, input logic [4:0] b,
                                  input logic [SLOT_W-1:0] s, input logic [SLOT_W-1:0] n);
    if (mode) return (s == {SLOT_W{1'b0}}) && (b == 5'd0);
    return {1'b0, s} >= (({1'b0, n} + (SLOT_W+1)'(1)) >> 1);
  endfunction

  for (genvar g = 0; g < NUM_GEN; g++) begin : g_gen
    state_e            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
    logic [4:0]        bit_q, bit_d, word_q, word_d;
    logic [SLOT_W-1:0] slot_q, slot_d, snum_q, snum_d;
    logic              mode_q, mode_d, dly_q, dly_d, pol_q, pol_d;
    logic              sck_q, sck_d, ws_q, ws_d;
    logic              rise_q, rise_d, fall_q, fall_d, fs_q, fs_d;
    logic              en, tick, fall_ev, wrap, load, ws_start;
    logic [DIV_W-1:0]  c_div;
    logic [4:0]        c_word, nb, nb2;
    logic [SLOT_W-1:0] c_snum, ns, ns2;
    logic              c_mode, c_dly, c_pol;

    assign en     = bus.en_i[g];
    assign c_div  = bus.cfg_div_i[g*DIV_W +: DIV_W];
    assign c_word = bus.cfg_word_size_i[g*5 +: 5];
    assign c_snum = bus.cfg_slot_num_i[g*SLOT_W +: SLOT_W];
    assign c_mode = bus.cfg_ws_mode_i[g];
    assign c_dly  = bus.cfg_ws_delay_i[g];
    assign c_pol  = bus.cfg_ws_pol_i[g];

    assign tick    = (cnt_q == div_q);
    assign fall_ev = (state_q != IDLE) && tick && sck_q;
    assign wrap    = fall_ev && (bit_q == word_q) && (slot_q == snum_q);

    // nb/ns is the position after this falling edge, nb2/ns2 the one after that
    assign nb  = next_bit(bit_q, word_q);
    assign ns  = next_slot(bit_q, word_q, slot_q, snum_q);
    assign nb2 = next_bit(nb, word_q);
    assign ns2 = next_slot(nb, word_q, ns, snum_q);

    // WS for position (0,0) of a frame that starts with the live config
    assign ws_start = ws_raw(c_mode,
                             c_dly ? next_bit(5'd0, c_word) : 5'd0,
                             c_dly ? next_slot(5'd0, c_word, {SLOT_W{1'b0}}, c_snum) : {SLOT_W{1'b0}},
                             c_snum) ^ c_pol;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sck_d   = sck_q;
      ws_d    = ws_q;
      bit_d   = bit_q;
      slot_d  = slot_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      fs_d    = 1'b0;
      load    = 1'b0;
      case (state_q)
        IDLE: begin
          sck_d  = 1'b0;
          cnt_d  = '0;
          bit_d  = '0;
          slot_d = '0;
          ws_d   = c_pol;
          if (en) begin
            state_d = RUN;
            load    = 1'b1;
            ws_d    = ws_start;
            fs_d    = 1'b1;
          end
        end
        default: begin
          if (en)        state_d = RUN;
          else if (wrap) state_d = IDLE;
          else           state_d = STOP;
          cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
          if (tick) begin
            sck_d  = ~sck_q;
            rise_d = ~sck_q;
            fall_d = sck_q;
          end
          if (wrap) begin
            bit_d  = '0;
            slot_d = '0;
            if (en) begin
              load = 1'b1;
              ws_d = ws_start;
              fs_d = 1'b1;
            end else begin
              ws_d = c_pol;
            end
          end else if (fall_ev) begin
            bit_d  = nb;
            slot_d = ns;
            ws_d   = ws_raw(mode_q, dly_q ? nb2 : nb, dly_q ? ns2 : ns, snum_q) ^ pol_q;
          end
        end
      endcase
      div_d  = load ? c_div  : div_q;
      word_d = load ? c_word : word_q;
      snum_d = load ? c_snum : snum_q;
      mode_d = load ? c_mode : mode_q;
      dly_d  = load ? c_dly  : dly_q;
      pol_d  = load ? c_pol  : pol_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        div_q   <= '0;
        bit_q   <= '0;
        word_q  <= '0;
        slot_q  <= '0;
        snum_q  <= '0;
        mode_q  <= 1'b0;
        dly_q   <= 1'b0;
        pol_q   <= 1'b0;
        sck_q   <= 1'b0;
        ws_q    <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        fs_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        div_q   <= div_d;
        bit_q   <= bit_d;
        word_q  <= word_d;
        slot_q  <= slot_d;
        snum_q  <= snum_d;
        mode_q  <= mode_d;
        dly_q   <= dly_d;
        pol_q   <= pol_d;
        sck_q   <= sck_d;
        ws_q    <= ws_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        fs_q    <= fs_d;
      end
    end

    assign bus.sck_o[g]                       = sck_q;
    assign bus.ws_o[g]                        = ws_q;
    assign bus.sck_rise_o[g]                  = rise_q;
    assign bus.sck_fall_o[g]                  = fall_q;
    assign bus.frame_start_o[g]               = fs_q;
    assign bus.slot_idx_o[g*SLOT_W +: SLOT_W] = slot_q;
    assign bus.busy_o[g]                      = (state_q != IDLE);
  end

endmodule

// File: doc/i2s_tdm_clkws_gen.md
Name: i2s_tdm_clkws_gen

Overview:
Multi-instance I2S/TDM bit-clock and word-select generator. All logic runs in the system clock domain; clock-enable style, no gated or muxed clocks. NUM_GEN independent generators each produce a divided SCK, a frame-sync WS, strobes and slot position for the uDMA I2S TX/RX channels. Adds TDM slot counts, pulse-mode WS, one-bit WS delay, WS polarity, frame-aligned config update and graceful stop.

Parameters:
NUM_GEN, 2, number of independent generators (g = 0..NUM_GEN-1)
DIV_W, 16, divider field width
SLOT_W, 3, slot-count field width (up to 2**SLOT_W slots per frame)

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
en_i  in  NUM_GEN  per-generator enable
cfg_div_i  in  NUM_GEN*DIV_W  SCK half-period minus 1, in clk_i cycles
cfg_word_size_i  in  NUM_GEN*5  bits per slot minus 1
cfg_slot_num_i  in  NUM_GEN*SLOT_W  slots per frame minus 1
cfg_ws_mode_i  in  NUM_GEN  0 = 50% I2S/LJ, 1 = one-SCK pulse
cfg_ws_delay_i  in  NUM_GEN  1 = WS leads the slot by one SCK
cfg_ws_pol_i  in  NUM_GEN  WS inversion
sck_o  out  NUM_GEN  bit clock
ws_o  out  NUM_GEN  word select
sck_rise_o  out  NUM_GEN  1-cycle strobe, same cycle sck_o goes 0->1
sck_fall_o  out  NUM_GEN  1-cycle strobe, same cycle sck_o goes 1->0
frame_start_o  out  NUM_GEN  1-cycle strobe at start of each frame
slot_idx_o  out  NUM_GEN*SLOT_W  current slot index
busy_o  out  NUM_GEN  generator not IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: all outputs 0. All counters 0. All generators IDLE.
- Generator fields: g uses bits [g*W +: W].
- Per-generator FSM states: IDLE, RUN, STOP.
- IDLE: sck_o = 0, strobes 0, counters 0. ws_o = cfg_ws_pol_i, registered each cycle.
- IDLE -> RUN: taken in the cycle en_i = 1.
  - All cfg_* are captured into shadow registers.
  - div counter is cleared; bit/slot position P is set to (0,0).
  - ws_o is loaded with the WS value for the start position (see below).
  - frame_start_o pulses in this same cycle.
- Divider: in RUN/STOP, cnt counts 0..div. At cnt == div, sck_o toggles and cnt returns to 0. SCK period = 2*(div+1) clk_i cycles; div = 0 gives period 2.
- First rising edge occurs div+1 cycles after RUN entry.
- Position advance: on each falling edge, bit_cnt increments. At bit_cnt == word_size, bit_cnt wraps to 0 and slot increments. At slot == slot_num, slot wraps to 0. This wrap is the frame boundary.
- frame_start_o pulses on the boundary falling edge.
- Shadow config reloads from cfg_* on every frame-boundary falling edge. Mid-frame cfg changes have no effect until then.
- WS: raw value f(P) for position P.
  - mode 0: f(P) = 1 when slot >= (slot_num+1)>>1.
  - mode 1: f(P) = 1 when slot == 0 and bit == 0.
- WS update: applied on falling edges (and on RUN entry). ws_o = f(P + delay) XOR pol.
  - P + delay wraps across the frame using the shadow config.
  - delay = 1 with mode 1: the pulse for the first frame after RUN entry is not produced; pulses appear from the second frame on.
- slot_idx_o = current slot of P.
- RUN -> STOP: taken in a cycle with en_i = 0 that is not a boundary falling edge.
- STOP: generation continues unchanged.
  - STOP -> IDLE at the next frame-boundary falling edge. sck_o is low there; frame_start_o does not pulse.
  - en_i = 1 while in STOP returns to RUN with no disturbance.
- RUN with en_i = 0 on a boundary falling edge: go directly to IDLE (no frame_start_o).
- busy_o = (state != IDLE).
- rst_i mid-operation: all outputs go to reset values immediately (asynchronous); the generator restarts from IDLE.
- Independence: generators share nothing except clk_i and rst_i.

Test Plan:
- g0: div=1, word=3, slot_num=1, mode0, delay0, pol0.
  -> sck period 4 clk_i.
  -> ws_o low 4 SCK, then high 4 SCK.
  -> frame_start_o every 32 clk_i.
  -> slot_idx_o sequence 0,1.
- Same as above with delay=1.
  -> every ws_o transition occurs one SCK (4 clk_i) earlier.
  -> frame_start_o timing unchanged.
  -> With pol=1, ws_o is the exact inverse.
- div=0, word=15, slot_num=7, mode1, delay0.
  -> ws_o high for exactly one SCK (2 clk_i) every 256 clk_i, coincident with frame_start_o.
  -> slot_idx_o steps 0..7.
- Graceful stop: drop en_i at slot 0 bit 2.
  -> SCK continues to the frame boundary, then sck_o = 0 and busy_o = 0.
  -> Repeat, re-raising en_i during STOP: no gap or glitch in sck_o.
- Shadow config: change div 1 -> 3 mid-frame.
  -> Old period is kept until the boundary; new period of 8 clk_i applies from the next frame.
- Assert rst_i mid-frame.
  -> All outputs 0 within the same cycle.
  -> After release with en_i = 1, the first sck_rise_o occurs div+1 cycles after RUN entry.
  -> g1 runs a different config concurrently, unaffected by g0 enable changes.
